// File: rtl/router_pkg.sv
// Shared types and widths for the router output mux.
// ROUTER_MUX_RR_EN selects round-robin over fixed-priority arbitration.
package router_pkg;

  localparam int DATA_W   = 64;
  localparam int DEST_W   = 8;
  localparam int NUMPORTS = 4;

  typedef struct packed {
    logic hdr;
    logic pld;
    logic sof;
    logic eof;
  } flit_flags_t;

  typedef enum logic {
    IDLE,
    BUSY
  } mux_state_t;

  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/router_arbiter.sv
// Request vector to one-hot grant for the output mux.
// ROUTER_MUX_RR_EN: rotating search pointer; otherwise lowest index wins.
module router_arbiter
  import router_pkg::*;
#(
  parameter  int Numports = NUMPORTS,
  localparam int IW       = idx_w(Numports)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [Numports-1:0] req,
  input  logic                upd,
  output logic [Numports-1:0] gnt,
  output logic [IW-1:0]       idx,
  output logic                any
);

`ifdef ROUTER_MUX_RR_EN
  logic [IW-1:0] ptr;

  always_comb begin
    int j;
    logic [IW-1:0] jj;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    jj  = '0;
    for (int k = 0; k < Numports; k++) begin
      j = int'(ptr) + k;
      if (j >= Numports) j = j - Numports;
      jj = IW'(j);
      if (!any && req[jj]) begin
        any     = 1'b1;
        gnt[jj] = 1'b1;
        idx     = jj;
      end
    end
  end

  // pointer lands just after the winner so it loses priority next round
  always_ff @(posedge CLK) begin
    if (!RST) begin
      ptr <= '0;
    end else if (upd && any) begin
      if (idx == IW'(Numports - 1)) ptr <= '0;
      else ptr <= idx + IW'(1);
    end
  end
`else
  logic unused_ok;
  assign unused_ok = ^{CLK, RST, upd};

  always_comb begin
    logic [IW-1:0] kk;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    kk  = '0;
    for (int k = Numports - 1; k >= 0; k--) begin
      kk = IW'(k);
      if (req[kk]) begin
        gnt     = '0;
        gnt[kk] = 1'b1;
        idx     = kk;
        any     = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/router_mux.sv
// Output-port mux: arbitrates inputs addressed to PortNo, forwards flits.
// ROUTER_MUX_RR_EN enables round-robin arbitration (default fixed priority).
module router_mux
  import router_pkg::*;
#(
  parameter  int Numports = NUMPORTS,
  parameter  int PortNo   = 0,
  localparam int IW       = idx_w(Numports)
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic [Numports-1:0][DATA_W-1:0]  D,
  input  logic [Numports-1:0][DEST_W-1:0]  DEST,
  input  logic [Numports-1:0]              DEST_VALID,
  input  logic [Numports-1:0]              D_HDR_VALID,
  input  logic [Numports-1:0]              D_PLD_VALID,
  input  logic [Numports-1:0]              D_SOF,
  input  logic [Numports-1:0]              D_EOF,
  input  logic                             Q_BP,
  output logic [Numports-1:0]              D_BP,
  output logic [Numports-1:0]              COLLISION,
  output logic [DATA_W-1:0]                Q,
  output logic                             Q_HDR_VALID,
  output logic                             Q_PLD_VALID,
  output logic                             Q_SOF,
  output logic                             Q_EOF
);

  mux_state_t          state;
  logic [IW-1:0]       gnt_q;
  logic [IW-1:0]       arb_idx;
  logic [IW-1:0]       cur;
  logic [Numports-1:0] req;
  logic [Numports-1:0] arb_gnt;
  logic [Numports-1:0] cur_gnt;
  logic                arb_any;
  logic                arb_upd;
  logic                have_g;
  logic                abort;
  logic                rel;
  flit_flags_t         fl;

  for (genvar i = 0; i < Numports; i++) begin : g_req
    assign req[i] = DEST_VALID[i] && (DEST[i] == DEST_W'(PortNo));
  end

  // arbitration only while idle and the output is free to accept
  assign arb_upd = (state == IDLE) && !Q_BP;

  router_arbiter #(
    .Numports(Numports)
  ) u_arb (
    .CLK(CLK),
    .RST(RST),
    .req(req),
    .upd(arb_upd),
    .gnt(arb_gnt),
    .idx(arb_idx),
    .any(arb_any)
  );

  always_comb begin
    cur     = gnt_q;
    cur_gnt = '0;
    have_g  = 1'b0;
    if (state == BUSY) begin
      cur_gnt[gnt_q] = 1'b1;
      have_g         = 1'b1;
    end else if (arb_upd && arb_any) begin
      cur     = arb_idx;
      cur_gnt = arb_gnt;
      have_g  = 1'b1;
    end
  end

  assign fl.hdr = D_HDR_VALID[cur];
  assign fl.pld = D_PLD_VALID[cur];
  assign fl.sof = D_SOF[cur];
  assign fl.eof = D_EOF[cur];

  assign abort = (state == BUSY) && !req[gnt_q];
  assign rel   = (state == BUSY) && !Q_BP && fl.eof && (fl.hdr || fl.pld);

  assign D_BP = RST ? ((req & ~cur_gnt) | (cur_gnt & {Numports{Q_BP}}))
                    : '0;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state       <= IDLE;
      gnt_q       <= '0;
      COLLISION   <= '0;
      Q           <= '0;
      Q_HDR_VALID <= 1'b0;
      Q_PLD_VALID <= 1'b0;
      Q_SOF       <= 1'b0;
      Q_EOF       <= 1'b0;
    end else begin
      COLLISION <= req & ~cur_gnt;

      unique case (state)
        IDLE: begin
          if (arb_upd && arb_any) begin
            gnt_q <= arb_idx;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (abort || rel) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // abort drops qualifiers even under backpressure; Q keeps last data
      if (abort) begin
        Q_HDR_VALID <= 1'b0;
        Q_PLD_VALID <= 1'b0;
        Q_SOF       <= 1'b0;
        Q_EOF       <= 1'b0;
      end else if (!Q_BP) begin
        if (have_g) begin
          Q           <= D[cur];
          Q_HDR_VALID <= fl.hdr;
          Q_PLD_VALID <= fl.pld;
          Q_SOF       <= fl.sof;
          Q_EOF       <= fl.eof;
        end else begin
          Q_HDR_VALID <= 1'b0;
          Q_PLD_VALID <= 1'b0;
          Q_SOF       <= 1'b0;
          Q_EOF       <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_router_mux.sv
// Randomized bench for router_mux against a packet-level reference model.
// Arbitration model follows ROUTER_MUX_RR_EN when defined.
module tb_router_mux;
  import router_pkg::*;

  localparam int N    = 4;
  localparam int PORT = 1;

  typedef struct packed {
    logic [63:0] data;
    logic        hdr;
    logic        pld;
    logic        sof;
    logic        eof;
  } flit_t;

  logic                CLK = 1'b0;
  logic                RST;
  logic [N-1:0][63:0]  D;
  logic [N-1:0][7:0]   DEST;
  logic [N-1:0]        DEST_VALID;
  logic [N-1:0]        D_HDR_VALID;
  logic [N-1:0]        D_PLD_VALID;
  logic [N-1:0]        D_SOF;
  logic [N-1:0]        D_EOF;
  logic                Q_BP;
  logic [N-1:0]        D_BP;
  logic [N-1:0]        COLLISION;
  logic [63:0]         Q;
  logic                Q_HDR_VALID;
  logic                Q_PLD_VALID;
  logic                Q_SOF;
  logic                Q_EOF;

  router_mux #(
    .Numports(N),
    .PortNo(PORT)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .D(D),
    .DEST(DEST),
    .DEST_VALID(DEST_VALID),
    .D_HDR_VALID(D_HDR_VALID),
    .D_PLD_VALID(D_PLD_VALID),
    .D_SOF(D_SOF),
    .D_EOF(D_EOF),
    .Q_BP(Q_BP),
    .D_BP(D_BP),
    .COLLISION(COLLISION),
    .Q(Q),
    .Q_HDR_VALID(Q_HDR_VALID),
    .Q_PLD_VALID(Q_PLD_VALID),
    .Q_SOF(Q_SOF),
    .Q_EOF(Q_EOF)
  );

  always #5 CLK = ~CLK;

  flit_t      src_q[N][$];
  int         src_dest[N];
  int         src_abort[N];
  int         src_sent[N];
  flit_t      exp_q[$];
  int         m_owner;
  int         m_ptr;
  logic [N-1:0] exp_coll;
  logic [N-1:0] bp_seen;
  logic       qbp_req;
  int         checks;
  int         errors;

  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(logic [N-1:0] r);
`ifdef ROUTER_MUX_RR_EN
    for (int k = 0; k < N; k++)
      if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
`else
    for (int k = 0; k < N; k++)
      if (r[k]) return k;
`endif
    return -1;
  endfunction

  task automatic start_pkt(int i, int dest, logic [63:0] hdr, int npld,
                           logic [63:0] base, logic [63:0] step, int ab);
    flit_t f;
    src_dest[i]  = dest;
    src_abort[i] = ab;
    src_sent[i]  = 0;
    f = '{data: hdr, hdr: 1'b1, pld: 1'b0, sof: 1'b1, eof: 1'b0};
    src_q[i].push_back(f);
    for (int k = 1; k <= npld; k++) begin
      f.data = base + 64'(k - 1) * step;
      f.hdr  = 1'b0;
      f.pld  = 1'b1;
      f.sof  = 1'b0;
      f.eof  = (k == npld);
      src_q[i].push_back(f);
    end
  endtask

  task automatic drive();
    flit_t f;
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        f              = src_q[i][0];
        D[i]           = f.data;
        D_HDR_VALID[i] = f.hdr;
        D_PLD_VALID[i] = f.pld;
        D_SOF[i]       = f.sof;
        D_EOF[i]       = f.eof;
        DEST[i]        = 8'(src_dest[i]);
        DEST_VALID[i]  = 1'b1;
      end else begin
        D[i]           = {$urandom, $urandom};
        D_HDR_VALID[i] = 1'($urandom);
        D_PLD_VALID[i] = 1'($urandom);
        D_SOF[i]       = 1'($urandom);
        D_EOF[i]       = 1'($urandom);
        DEST[i]        = 8'($urandom);
        DEST_VALID[i]  = 1'b0;
      end
      r[i] = DEST_VALID[i] && (DEST[i] == 8'(PORT));
    end
    // keep aborts away from stalled cycles so no held flit is dropped
    if (RST && m_owner >= 0 && !r[m_owner]) Q_BP = 1'b0;
    else Q_BP = qbp_req;
  endtask

  task automatic tick();
    logic [N-1:0] req;
    logic [N-1:0] gv;
    logic [N-1:0] ebp;
    flit_t        obs;
    flit_t        cf;
    logic         rst_e;
    bit           ab;
    int           g;
    drive();
    #1;
    rst_e = RST;
    for (int i = 0; i < N; i++)
      req[i] = DEST_VALID[i] && (DEST[i] == 8'(PORT));
    if (!rst_e) begin
      chk("d_bp_rst", D_BP, '0);
    end else begin
      ab = (m_owner >= 0) && !req[m_owner];
      g  = -1;
      if (m_owner >= 0) g = m_owner;
      else if (!Q_BP && req != '0) g = pick(req);
      gv = '0;
      if (g >= 0) gv[g] = 1'b1;
      ebp = (req & ~gv) | (Q_BP ? gv : '0);
      chk("d_bp", D_BP, ebp);
      obs = {Q, Q_HDR_VALID, Q_PLD_VALID, Q_SOF, Q_EOF};
      if (exp_q.size() > 0) begin
        chk("q_flit", obs, exp_q[0]);
        if (!Q_BP) void'(exp_q.pop_front());
      end else begin
        chk("q_idle", {Q_HDR_VALID, Q_PLD_VALID, Q_SOF, Q_EOF}, 4'b0);
      end
      if (g >= 0 && !ab && !Q_BP) begin
        cf = {D[g], D_HDR_VALID[g], D_PLD_VALID[g], D_SOF[g], D_EOF[g]};
        if (cf.hdr || cf.pld) exp_q.push_back(cf);
      end
      if (ab) begin
        m_owner = -1;
      end else if (m_owner < 0 && g >= 0) begin
        m_owner = g;
        m_ptr   = (g + 1) % N;
      end else if (m_owner >= 0 && !Q_BP && D_EOF[g] &&
                   (D_HDR_VALID[g] || D_PLD_VALID[g])) begin
        m_owner = -1;
      end
      exp_coll = req & ~gv;
    end
    bp_seen = D_BP;
    @(posedge CLK);
    #1;
    if (!rst_e) begin
      chk("coll_rst", COLLISION, '0);
      chk("q_rst", {Q, Q_HDR_VALID, Q_PLD_VALID, Q_SOF, Q_EOF}, '0);
      m_owner = -1;
      m_ptr   = 0;
      exp_q.delete();
      for (int i = 0; i < N; i++) src_q[i].delete();
    end else begin
      chk("collision", COLLISION, exp_coll);
      for (int i = 0; i < N; i++) begin
        if (src_q[i].size() > 0 && !bp_seen[i]) begin
          void'(src_q[i].pop_front());
          src_sent[i]++;
          if (src_abort[i] > 0 && src_sent[i] == src_abort[i])
            src_q[i].delete();
        end
      end
    end
    @(negedge CLK);
  endtask

  task automatic run_idle(int budget);
    int n;
    bit busy;
    n = 0;
    do begin
      tick();
      n++;
      busy = (m_owner >= 0) || (exp_q.size() > 0);
      for (int i = 0; i < N; i++)
        if (src_q[i].size() > 0) busy = 1'b1;
    end while (busy && n < budget);
    if (busy) chk("timeout", 1, 0);
    tick();
  endtask

  initial begin
    int np;
    checks   = 0;
    errors   = 0;
    m_owner  = -1;
    m_ptr    = 0;
    exp_coll = '0;
    qbp_req  = 1'b0;
    RST      = 1'b0;
    for (int i = 0; i < N; i++) begin
      src_dest[i]  = 0;
      src_abort[i] = -1;
      src_sent[i]  = 0;
    end
    @(negedge CLK);
    tick();
    tick();
    RST = 1'b1;
    tick();

    // simultaneous contested SOF on inputs 0 and 1
    start_pkt(0, 1, {8'h1, 56'h1}, 10, 64'd1, 64'd1, -1);
    start_pkt(1, 1, {8'h1, 56'h2}, 10, 64'd16, 64'd16, -1);
    run_idle(200);

    // lone requester
    start_pkt(1, 1, {8'h1, 56'h3}, 10, 64'd16, 64'd16, -1);
    run_idle(200);

    // backpressure for 3 cycles mid-payload
    start_pkt(0, 1, {8'h1, 56'h4}, 10, 64'd100, 64'd1, -1);
    repeat (4) tick();
    qbp_req = 1'b1;
    repeat (3) tick();
    qbp_req = 1'b0;
    run_idle(200);

    // other destination, then abort mid-packet
    start_pkt(2, 2, {8'h2, 56'h5}, 5, 64'd7, 64'd1, -1);
    run_idle(200);
    start_pkt(0, 1, {8'h1, 56'h6}, 10, 64'd50, 64'd1, 4);
    run_idle(200);

    // reset mid-packet
    start_pkt(3, 1, {8'h1, 56'h7}, 10, 64'd70, 64'd1, -1);
    repeat (4) tick();
    RST = 1'b0;
    tick();
    RST = 1'b1;
    tick();

    // back-to-back contested packets: input 0 has two, input 1 one
    start_pkt(0, 1, {8'h1, 56'h8}, 3, 64'h80, 64'd1, -1);
    start_pkt(0, 1, {8'h1, 56'h9}, 3, 64'h90, 64'd1, -1);
    start_pkt(1, 1, {8'h1, 56'hA}, 3, 64'hA0, 64'd1, -1);
    run_idle(200);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (src_q[i].size() == 0 && $urandom_range(0, 2) == 0) begin
          np = $urandom_range(1, 5);
          start_pkt(i, $urandom_range(0, 2),
                    {8'(i + 1), 24'($urandom), 32'($urandom)}, np,
                    {$urandom, $urandom}, 64'd1,
                    ($urandom_range(0, 7) == 0) ? $urandom_range(1, np) : -1);
        end
      end
      qbp_req = ($urandom_range(0, 4) == 0);
      tick();
    end
    qbp_req = 1'b0;
    run_idle(500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_mux.md
ROUTER_MUX -- requirements
Module: router_mux

Interface
- REQ-001: Numports, default 4, number of router input ports feeding this mux.
- REQ-002: PortNo, default 0, output port number this mux serves; compared against DEST.
- REQ-003: CLK  input  1  single clock; all state updates on rising edge.
- REQ-004: RST  input  1  synchronous, active-low reset.
- REQ-005: D  input  [Numports][64]  per-input data flit.
- REQ-006: DEST  input  [Numports][8]  per-input destination port number.
- REQ-007: DEST_VALID  input  Numports  per-input DEST qualifier; held for the whole packet.
- REQ-008: D_HDR_VALID, D_PLD_VALID  input  Numports each  header / payload flit valid.
- REQ-009: D_SOF, D_EOF  input  Numports each  start / end of packet markers.
- REQ-010: Q_BP  input  1  downstream backpressure; high stalls this output.
- REQ-011: D_BP  output  Numports  backpressure to each input.
- REQ-012: COLLISION  output  Numports  input requested this output but was not granted.
- REQ-013: Q  output  64  muxed data; Q_HDR_VALID, Q_PLD_VALID, Q_SOF, Q_EOF  output  1 each  muxed qualifiers.

Function
- REQ-014: req[i] = DEST_VALID[i] && DEST[i]==PortNo (8-bit compare, PortNo zero-extended).
- REQ-015: States IDLE and BUSY; in IDLE with any req, winner picked combinationally, grant register loads the winner, state -> BUSY.
- REQ-016: Winner: round-robin; search starts at input after last winner, wrapping Numports-1 -> 0; pointer after reset = 0.
- REQ-017: In BUSY, grant held until D_EOF[g] with D_HDR_VALID[g] or D_PLD_VALID[g] accepted (Q_BP low), or DEST_VALID[g] drops (abort); then -> IDLE.
- REQ-018: New grant no earlier than the cycle after release; one idle cycle between packets.
- REQ-019: Output register: when granted input g (BUSY, or the IDLE winner in its arbitration cycle) and Q_BP low, Q/Q_HDR_VALID/Q_PLD_VALID/Q_SOF/Q_EOF <= D/flags of g; one-cycle latency.
- REQ-020: No grant, or abort cycle: valid/SOF/EOF outputs <= 0, Q holds its last value.
- REQ-021: Q_BP high: output register holds, D_BP[g]=1, grant/state unchanged.
- REQ-022: D_BP[i] combinational = (req[i] && i not granted) || (i granted && Q_BP); 0 for non-requesting inputs.
- REQ-023: COLLISION[i] registered = req[i] && i not granted this cycle; clears when req[i] drops or i granted.
- REQ-024: Flags of non-granted inputs never reach outputs; multi-requester simultaneous SOF resolved only by REQ-016.

Reset
- REQ-025: RST low at clock edge: state IDLE, grant none, RR pointer 0, Q=0, all Q_* flags 0, COLLISION=0; D_BP=0 while RST low.
- REQ-026: Reset mid-packet discards the packet; no EOF emitted.

Configuration
- REQ-027: ROUTER_MUX_RR_EN defined: round-robin per REQ-016; undefined: fixed priority, lowest index wins, pointer logic removed.

Structure
- REQ-028: Shared package router_pkg: data width 64, DEST width 8, default Numports, flit flag struct (hdr, pld, sof, eof).
- REQ-029: Sub-module router_arbiter: Numports-wide request -> one-hot grant, RR pointer, update-enable input.

Verification
- REQ-030: PortNo=1; inputs 0,1 DEST=1, DEST_VALID+D_SOF same cycle -> input 0 granted, COLLISION[1]=1, D_BP[1]=1 next cycle, D_BP[0]=0.
- REQ-031: Granted input 0 sends header {8'h1,56'h1} then payloads 10,1..9,10 with EOF on last -> Q shows same sequence one cycle later, Q_EOF on flit 10, then all valids 0.
- REQ-032: After release, input 1 alone DEST_VALID+SOF, payloads 10,16..160 -> granted, Q follows one cycle later, COLLISION[1]=0.
- REQ-033: Q_BP=1 for 3 cycles mid-payload -> Q frozen, D_BP[g]=1, no flit lost or duplicated after release.
- REQ-034: DEST=2 at PortNo=1 -> no grant, D_BP/COLLISION 0; DEST_VALID dropped mid-packet -> IDLE next cycle, no Q_EOF.
- REQ-035: RST low mid-packet -> all outputs 0 next cycle; with ROUTER_MUX_RR_EN, two back-to-back contested packets alternate winners 0 then 1.
